// File: rtl/alu_exec_unit_if.sv
// Instruction issue / register-write / result bus between the decoder and alu_exec_unit.
interface alu_exec_unit_if;
  logic        start;
  logic [1:0]  op;
  logic [1:0]  shift;
  logic [2:0]  rn;
  logic [2:0]  rm;
  logic [2:0]  rd;
  logic        asel;
  logic        bsel;
  logic [15:0] imm;
  logic        wr_en;
  logic        ld_status;
  logic        ext_we;
  logic [2:0]  ext_wnum;
  logic [15:0] ext_wdata;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic [2:0]  status;

  modport master (
    output start, op, shift, rn, rm, rd, asel, bsel, imm, wr_en, ld_status,
           ext_we, ext_wnum, ext_wdata,
    input  busy, done, result, status
  );

  modport slave (
    input  start, op, shift, rn, rm, rd, asel, bsel, imm, wr_en, ld_status,
           ext_we, ext_wnum, ext_wdata,
    output busy, done, result, status
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Multi-cycle execute unit: 8x16 register file, A/B/C/status registers, ALU and B-path shifter.
// state | meaning: IDLE wait for start | LOADA A<=R[rn] | LOADB B<=R[rm] | EXEC C/status update | WB done, R[rd]<=C

module alu_exec_shifter (
  input  logic [15:0] i_b,
  input  logic [1:0]  i_shift,
  output logic [15:0] o_out
);
  always_comb begin
    o_out = i_b;
    case (i_shift)
      2'b00: o_out = i_b;
      2'b01: o_out = {i_b[14:0], 1'b0};
      2'b10: o_out = {1'b0, i_b[15:1]};
      2'b11: o_out = {i_b[15], i_b[15:1]};
      default: o_out = i_b;
    endcase
  end
endmodule

module alu_exec_alu (
  input  logic [15:0] i_ain,
  input  logic [15:0] i_bin,
  input  logic [1:0]  i_op,
  output logic [15:0] o_out,
  output logic [2:0]  o_status
);
  logic [15:0] w_sum;
  logic [15:0] w_diff;
  logic        w_v;

  assign w_sum  = i_ain + i_bin;
  assign w_diff = i_ain - i_bin;

  always_comb begin
    o_out = w_sum;
    w_v   = 1'b0;
    case (i_op)
      2'b00: begin
        o_out = w_sum;
        w_v   = (i_ain[15] == i_bin[15]) && (w_sum[15] != i_ain[15]);
      end
      2'b01: begin
        o_out = w_diff;
        w_v   = (i_ain[15] != i_bin[15]) && (w_diff[15] != i_ain[15]);
      end
      2'b10: o_out = i_ain & i_bin;
      2'b11: o_out = ~i_bin;
      default: o_out = w_sum;
    endcase
  end

  // status = {N, V, Z}; V only meaningful for add/sub, cleared for logic ops
  assign o_status = {o_out[15], w_v, (o_out == 16'h0000)};
endmodule

module alu_exec_unit (
  input  logic            clk,
  input  logic            reset,
  alu_exec_unit_if.slave  bus
);
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOADA = 3'd1,
    S_LOADB = 3'd2,
    S_EXEC  = 3'd3,
    S_WB    = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [15:0] r_regs [8];
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic [15:0] r_c;
  logic [2:0]  r_status;

  logic [1:0]  r_op;
  logic [1:0]  r_shift;
  logic [2:0]  r_rn;
  logic [2:0]  r_rm;
  logic [2:0]  r_rd;
  logic        r_asel;
  logic        r_bsel;
  logic [15:0] r_imm;
  logic        r_wr_en;
  logic        r_ld_status;

  logic [15:0] w_bshift;
  logic [15:0] w_ain;
  logic [15:0] w_bin;
  logic [15:0] w_alu_out;
  logic [2:0]  w_alu_status;
  logic        w_busy;
  logic        w_done;

  alu_exec_shifter u_shifter (
    .i_b     (r_b),
    .i_shift (r_shift),
    .o_out   (w_bshift)
  );

  assign w_ain = r_asel ? 16'h0000 : r_a;
  assign w_bin = r_bsel ? r_imm : w_bshift;

  alu_exec_alu u_alu (
    .i_ain    (w_ain),
    .i_bin    (w_bin),
    .i_op     (r_op),
    .o_out    (w_alu_out),
    .o_status (w_alu_status)
  );

  always_comb begin
    w_next = r_state;
    w_busy = 1'b1;
    w_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (bus.start) w_next = S_LOADA;
      end
      S_LOADA: w_next = S_LOADB;
      S_LOADB: w_next = S_EXEC;
      S_EXEC:  w_next = S_WB;
      S_WB: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      for (int i = 0; i < 8; i++) r_regs[i] <= 16'h0000;
      r_a         <= 16'h0000;
      r_b         <= 16'h0000;
      r_c         <= 16'h0000;
      r_status    <= 3'b000;
      r_op        <= 2'b00;
      r_shift     <= 2'b00;
      r_rn        <= 3'd0;
      r_rm        <= 3'd0;
      r_rd        <= 3'd0;
      r_asel      <= 1'b0;
      r_bsel      <= 1'b0;
      r_imm       <= 16'h0000;
      r_wr_en     <= 1'b0;
      r_ld_status <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          // a same-cycle direct write lands here, so LOADA already sees it
          if (bus.ext_we) r_regs[bus.ext_wnum] <= bus.ext_wdata;
          if (bus.start) begin
            r_op        <= bus.op;
            r_shift     <= bus.shift;
            r_rn        <= bus.rn;
            r_rm        <= bus.rm;
            r_rd        <= bus.rd;
            r_asel      <= bus.asel;
            r_bsel      <= bus.bsel;
            r_imm       <= bus.imm;
            r_wr_en     <= bus.wr_en;
            r_ld_status <= bus.ld_status;
          end
        end
        S_LOADA: r_a <= r_regs[r_rn];
        S_LOADB: r_b <= r_regs[r_rm];
        S_EXEC: begin
          r_c <= w_alu_out;
          if (r_ld_status) r_status <= w_alu_status;
        end
        S_WB: begin
          if (r_wr_en) r_regs[r_rd] <= r_c;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = w_busy;
  assign bus.done   = w_done;
  assign bus.result = r_c;
  assign bus.status = r_status;
endmodule
